alu_md_controller: RTL and testbench
====================================

Name: alu_md_controller

Overview:
- Successor to the combinational ALU control decoder. Keeps the same 4-bit Operation encoding for base RV32I/RV64I ALU ops.
- Adds the RISC-V M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), parametrised in XLEN.
- M ops run on an internal iterative radix-2 multiply/divide engine with a stall handshake to the execute stage.
- Sits in EX, beside the ALU. Its result is muxed onto the writeback path when md_valid is high.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64
ENABLE_M, 1, 1 = M extension present; 0 = M ops decode as 4'b1111, never stall
(localparam CNT_W = $clog2(XLEN)+1, iteration counter width)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ALUOp  in  2  00 LW/SW, 01 branch, 10 R/I-type, 11 jump
Funct7  in  7  instr[31:25]
Funct3  in  3  instr[14:12]
InValid  in  1  EX-stage instruction valid, qualifies M requests
Flush  in  1  synchronous abort of any M op in flight
SrcA  in  XLEN  rs1 value
SrcB  in  XLEN  rs2 value
Operation  out  4  ALU operation code, combinational
md_stall  out  1  hold pipeline, combinational
md_valid  out  1  M result valid, one-cycle pulse, registered
md_result  out  XLEN  M result, registered

Behaviour:
- Operation decode (combinational, independent of state):
  - ALUOp=00 or 11 -> 0000.
  - ALUOp=01 by Funct3: 000->1010, 001->1011, 101->1100, 100->1101, else 1111.
  - ALUOp=10, Funct7 != 0000001, by Funct3:
    - 000 -> 0000, or 0001 when Funct7=0100000.
    - 100 -> 0010; 110 -> 0011; 111 -> 0100; 001 -> 0110.
    - 101 -> 0101 when Funct7=0000000; 0111 when Funct7=0100000.
    - 010 -> 1000; 011 -> 1001; else 1111.
  - ALUOp=10, Funct7=0000001 -> 1111 (ALU unused).
- md_req = ENABLE_M & InValid & ALUOp==10 & Funct7==0000001 & state==IDLE & !Flush.
- FSM states IDLE, BUSY, DONE:
  - IDLE: on md_req, latch SrcA, SrcB, Funct3 and operand signs; take absolute values for signed ops; counter<=0; go to BUSY.
  - BUSY: one shift-add (mul) or one restoring shift-subtract (div) step per cycle. Counter increments each cycle. After XLEN steps (counter==XLEN-1) go to DONE; the final-sign-corrected result is written to md_result on that transition.
  - DONE: md_valid=1 for exactly this cycle; next state IDLE.
- md_stall = md_req | (state==BUSY). It is low in DONE, so the pipeline advances and captures md_result that cycle.
- Fixed latency: request in cycle 0 -> md_valid in cycle XLEN+1 (33 for XLEN=32). This holds for every op, including the special cases below.
- Result selection by Funct3:
  - 000 MUL: low XLEN of the product.
  - 001 MULH (s×s), 010 MULHSU (s×u), 011 MULHU (u×u): high XLEN of the product.
  - 100 DIV / 101 DIVU: quotient.
  - 110 REM / 111 REMU: remainder.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow (DIV/REM of -2^(XLEN-1) by -1): quotient = -2^(XLEN-1); remainder = 0.
- md_result holds its value until the next DONE. It is not cleared in IDLE.
- Flush:
  - In BUSY or DONE: next state IDLE and md_valid=0 the following cycle; no result is written.
  - In the same cycle as a would-be request: the request is ignored.
- InValid low, or a non-M instruction, in IDLE: no state change.
- A new request is never accepted outside IDLE.
- Reset (asynchronous, any state, including mid-op): state=IDLE, counter=0, md_valid=0, md_result=0, latched operands=0. md_stall falls immediately, since state leaves BUSY.
- ENABLE_M=0: FSM is tied to IDLE; md_stall=0, md_valid=0, md_result=0.

Test Plan:
- Decode sweep: ALUOp=10/F3=000/F7=0100000 -> Operation=0001; ALUOp=10/F3=101/F7=0100000 -> 0111; ALUOp=01/F3=100 -> 1101; ALUOp=11 -> 0000; ALUOp=10/F3=000/F7=0000001 -> 1111 with md_stall=1.
- XLEN=32, MUL SrcA=7, SrcB=0xFFFFFFFD -> md_stall high cycles 0..32, md_valid=1 at cycle 33, md_result=0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000×0x80000000 -> 0x40000000.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0. Each still has latency 33.
- Flush asserted at cycle 10 of a DIV -> IDLE at cycle 11, no md_valid pulse, md_stall=0. A back-to-back MUL issued at cycle 12 completes normally at cycle 45.
- rst_n low at cycle 20 of a MUL -> md_stall and md_valid drop asynchronously, md_result=0. After release, a new DIVU 9/3 returns 3 after 33 cycles.

Source files
------------

// File: rtl/alu_md_controller.sv
// EX-stage ALU operation decoder plus an iterative radix-2 multiply/divide engine
// for the RISC-V M extension, with a stall handshake toward the pipeline.
module alu_md_controller #(
   parameter int XLEN     = 32,
   parameter int ENABLE_M = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic            InValid,
   input  logic            Flush,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic [3:0]      Operation,
   output logic            md_stall,
   output logic            md_valid,
   output logic [XLEN-1:0] md_result
);
   localparam int   CNT_W = $clog2(XLEN) + 1;
   localparam logic M_ON  = (ENABLE_M != 0);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   opnd, hi, lo;
   logic [2:0]        f3;
   logic              sign_a, sign_b, div_zero;

   logic              is_m, md_req;
   logic              a_signed, b_signed, sa, sb;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic [XLEN:0]     sum, rsh, diff;
   logic [XLEN-1:0]   nhi, nlo, mulh_neg, quo, rem, res;

   always_comb begin
      Operation = 4'b1111;
      case (ALUOp)
         2'b00, 2'b11: Operation = 4'b0000;
         2'b01: case (Funct3)
            3'b000:  Operation = 4'b1010;
            3'b001:  Operation = 4'b1011;
            3'b101:  Operation = 4'b1100;
            3'b100:  Operation = 4'b1101;
            default: Operation = 4'b1111;
         endcase
         default: if (Funct7 != 7'b0000001) begin
            case (Funct3)
               3'b000:  Operation = (Funct7 == 7'b0100000) ? 4'b0001 : 4'b0000;
               3'b100:  Operation = 4'b0010;
               3'b110:  Operation = 4'b0011;
               3'b111:  Operation = 4'b0100;
               3'b001:  Operation = 4'b0110;
               3'b101:  Operation = (Funct7 == 7'b0000000) ? 4'b0101 :
                                    (Funct7 == 7'b0100000) ? 4'b0111 : 4'b1111;
               3'b010:  Operation = 4'b1000;
               3'b011:  Operation = 4'b1001;
               default: Operation = 4'b1111;
            endcase
         end
      endcase
   end

   // Handshake: md_stall high means EX must hold its instruction; it is high in
   // the request cycle and every BUSY cycle, low in DONE, where md_valid pulses
   // and the pipeline advances, capturing md_result in that same cycle.
   assign is_m     = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
   assign md_req   = M_ON && InValid && is_m && (state == IDLE) && !Flush;
   assign md_stall = md_req || (state == BUSY);

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (Funct3)
         3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
         3'b010:                 a_signed = 1'b1;
         default: ;
      endcase
      sa    = a_signed & SrcA[XLEN-1];
      sb    = b_signed & SrcB[XLEN-1];
      a_abs = sa ? -SrcA : SrcA;
      b_abs = sb ? -SrcB : SrcB;
   end

   // One engine step: mul shifts {hi,lo} right after adding opnd; div shifts
   // {hi,lo} left and restores hi when the trial subtract goes negative.
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      rsh  = {hi, lo[XLEN-1]};
      diff = rsh - {1'b0, opnd};
      if (f3[2]) begin
         nhi = diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0];
         nlo = {lo[XLEN-2:0], !diff[XLEN]};
      end else begin
         nhi = sum[XLEN:1];
         nlo = {sum[0], lo[XLEN-1:1]};
      end
      mulh_neg = ~nhi + XLEN'(nlo == '0);
      quo      = div_zero ? '1 : ((sign_a ^ sign_b) ? -nlo : nlo);
      rem      = sign_a ? -nhi : nhi;
      case (f3)
         3'b000:                 res = nlo;
         3'b001, 3'b010, 3'b011: res = (sign_a ^ sign_b) ? mulh_neg : nhi;
         3'b100, 3'b101:         res = quo;
         default:                res = rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         opnd      <= '0;
         hi        <= '0;
         lo        <= '0;
         f3        <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         div_zero  <= 1'b0;
         md_valid  <= 1'b0;
         md_result <= '0;
      end else begin
         md_valid <= 1'b0;
         case (state)
            IDLE: if (md_req) begin
               f3       <= Funct3;
               sign_a   <= sa;
               sign_b   <= sb;
               div_zero <= (SrcB == '0);
               opnd     <= Funct3[2] ? b_abs : a_abs;
               lo       <= Funct3[2] ? a_abs : b_abs;
               hi       <= '0;
               cnt      <= '0;
               state    <= BUSY;
            end
            BUSY: if (Flush) begin
               state <= IDLE;
            end else begin
               hi  <= nhi;
               lo  <= nlo;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(XLEN - 1)) begin
                  state     <= DONE;
                  md_valid  <= 1'b1;
                  md_result <= res;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_md_controller.sv
// Bench for alu_md_controller (XLEN=32): decode vector table, M-op vector table
// with a result scoreboard, plus flush, reset and operand-hold sequences.
module tb_alu_md_controller;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  ALUOp;
   logic [6:0]  Funct7;
   logic [2:0]  Funct3;
   logic        InValid, Flush;
   logic [31:0] SrcA, SrcB;
   logic [3:0]  Operation;
   logic        md_stall, md_valid;
   logic [31:0] md_result;

   int n_checks = 0;
   int n_err    = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   typedef struct {
      logic [1:0] aluop; logic [6:0] f7; logic [2:0] f3;
      logic valid; logic flush; logic [3:0] op; logic stall;
   } dec_vec_t;
   typedef struct {
      string name; logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] exp;
   } md_vec_t;
   dec_vec_t dec_tab[$];
   md_vec_t  md_tab[$];

   alu_md_controller #(.XLEN(32), .ENABLE_M(1)) dut (
      .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
      .InValid(InValid), .Flush(Flush), .SrcA(SrcA), .SrcB(SrcB),
      .Operation(Operation), .md_stall(md_stall), .md_valid(md_valid), .md_result(md_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every md_valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && md_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_valid: md_valid=1 result=%0h, expected no pulse", md_result);
         end else begin
            check({name_q.pop_front(), "_result"}, 64'(md_result), 64'(exp_q.pop_front()));
         end
      end
   end

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa64, sb64, sp;
      logic [63:0] up;
      logic signed [31:0] as, bs;
      sa64 = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      as = a;
      bs = b;
      case (f3)
         3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
         3'd1: begin sp = sa64 * sb64; return sp[63:32]; end
         3'd2: begin sp = sa64 * $signed({32'b0, b}); return sp[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: if (b == 0) return 32'hFFFFFFFF;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
               else return 32'(as / bs);
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: if (b == 0) return a;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
               else return 32'(as % bs);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic add_dec(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                          input logic valid, input logic flush, input logic [3:0] op, input logic stall);
      dec_vec_t v;
      v.aluop = aluop; v.f7 = f7; v.f3 = f3; v.valid = valid; v.flush = flush; v.op = op; v.stall = stall;
      dec_tab.push_back(v);
   endtask

   task automatic add_md(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      md_vec_t v;
      v.name = name; v.f3 = f3; v.a = a; v.b = b; v.exp = exp;
      md_tab.push_back(v);
   endtask

   task automatic idle_inputs();
      ALUOp = 2'b00; Funct7 = '0; Funct3 = '0; InValid = 1'b0; Flush = 1'b0;
   endtask

   // Called just after a rising edge; that cycle is cycle 0 of the request.
   task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit push);
      ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; SrcA = a; SrcB = b; InValid = 1'b1;
      if (push) begin
         exp_q.push_back(exp);
         name_q.push_back(name);
      end
      #1;
      check({name, "_stall_at_req"}, 64'(md_stall), 64'd1);
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic wait_done(input string name);
      bit seen, stall_ok;
      seen = 1'b0;
      stall_ok = 1'b1;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         if (md_valid) begin
            seen = 1'b1;
            check({name, "_latency"}, 64'(k), 64'd33);
            check({name, "_stall_in_done"}, 64'(md_stall), 64'd0);
         end else if (!md_stall) begin
            stall_ok = 1'b0;
         end
      end
      check({name, "_valid_seen"}, 64'(seen), 64'd1);
      check({name, "_stall_while_busy"}, 64'(stall_ok), 64'd1);
   endtask

   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      @(posedge clk); #1;
      issue(name, f3, a, b, exp, 1'b1);
      wait_done(name);
   endtask

   initial begin
      rst_n = 1'b0;
      SrcA = '0; SrcB = '0;
      idle_inputs();

      add_dec(2'b10, 7'b0100000, 3'b000, 1, 0, 4'b0001, 0);
      add_dec(2'b10, 7'b0000000, 3'b000, 1, 0, 4'b0000, 0);
      add_dec(2'b10, 7'b0100000, 3'b101, 1, 0, 4'b0111, 0);
      add_dec(2'b10, 7'b0000000, 3'b101, 1, 0, 4'b0101, 0);
      add_dec(2'b10, 7'b0011111, 3'b101, 1, 0, 4'b1111, 0);
      add_dec(2'b10, 7'b0000000, 3'b100, 1, 0, 4'b0010, 0);
      add_dec(2'b10, 7'b0000000, 3'b110, 1, 0, 4'b0011, 0);
      add_dec(2'b10, 7'b0000000, 3'b111, 1, 0, 4'b0100, 0);
      add_dec(2'b10, 7'b0000000, 3'b001, 1, 0, 4'b0110, 0);
      add_dec(2'b10, 7'b0000000, 3'b010, 1, 0, 4'b1000, 0);
      add_dec(2'b10, 7'b0000000, 3'b011, 1, 0, 4'b1001, 0);
      add_dec(2'b01, 7'b0000000, 3'b000, 1, 0, 4'b1010, 0);
      add_dec(2'b01, 7'b0000000, 3'b001, 1, 0, 4'b1011, 0);
      add_dec(2'b01, 7'b0000000, 3'b101, 1, 0, 4'b1100, 0);
      add_dec(2'b01, 7'b0000000, 3'b100, 1, 0, 4'b1101, 0);
      add_dec(2'b01, 7'b0000000, 3'b010, 1, 0, 4'b1111, 0);
      add_dec(2'b11, 7'b0100000, 3'b101, 1, 0, 4'b0000, 0);
      add_dec(2'b00, 7'b0000001, 3'b000, 1, 0, 4'b0000, 0);
      add_dec(2'b10, 7'b0000001, 3'b000, 1, 0, 4'b1111, 1);
      add_dec(2'b10, 7'b0000001, 3'b100, 1, 0, 4'b1111, 1);
      add_dec(2'b10, 7'b0000001, 3'b000, 0, 0, 4'b1111, 0);
      add_dec(2'b10, 7'b0000001, 3'b110, 1, 1, 4'b1111, 0);

      add_md("mul_7_m3",      3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB);
      add_md("mulhu_max",     3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE);
      add_md("mulh_min",      3'd1, 32'h80000000,   32'h80000000, 32'h40000000);
      add_md("mulh_m1_m1",    3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000);
      add_md("mulhsu_m1_2",   3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF);
      add_md("mul_shift",     3'd0, 32'h12345678,   32'h10,       32'h23456780);
      add_md("div_m7_2",      3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD);
      add_md("rem_m7_2",      3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF);
      add_md("div_7_m2",      3'd4, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD);
      add_md("rem_7_m2",      3'd6, 32'd7,          32'hFFFFFFFE, 32'd1);
      add_md("divu_100_7",    3'd5, 32'd100,        32'd7,        32'd14);
      add_md("remu_100_7",    3'd7, 32'd100,        32'd7,        32'd2);
      add_md("div_5_0",       3'd4, 32'd5,          32'd0,        32'hFFFFFFFF);
      add_md("rem_5_0",       3'd6, 32'd5,          32'd0,        32'd5);
      add_md("div_m5_0",      3'd4, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF);
      add_md("remu_max_0",    3'd7, 32'hFFFFFFFF,   32'd0,        32'hFFFFFFFF);
      add_md("div_ovf",       3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000);
      add_md("rem_ovf",       3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h00000000);

      repeat (3) @(posedge clk);
      #1;
      check("reset_stall", 64'(md_stall), 64'd0);
      check("reset_valid", 64'(md_valid), 64'd0);
      check("reset_result", 64'(md_result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (dec_tab[i]) begin
         @(negedge clk);
         ALUOp = dec_tab[i].aluop; Funct7 = dec_tab[i].f7; Funct3 = dec_tab[i].f3;
         InValid = dec_tab[i].valid; Flush = dec_tab[i].flush;
         #1;
         check($sformatf("decode%0d_op", i), 64'(Operation), 64'(dec_tab[i].op));
         check($sformatf("decode%0d_stall", i), 64'(md_stall), 64'(dec_tab[i].stall));
         idle_inputs();
      end
      @(negedge clk);
      check("decode_no_start", 64'(md_stall), 64'd0);

      foreach (md_tab[i])
         run_op(md_tab[i].name, md_tab[i].f3, md_tab[i].a, md_tab[i].b, md_tab[i].exp);

      // Result must persist through idle cycles, including ignored M instructions.
      ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
      repeat (3) @(negedge clk);
      check("invalid_low_no_stall", 64'(md_stall), 64'd0);
      idle_inputs();
      check("result_hold", 64'(md_result), 64'h00000000);

      for (int r = 0; r < 8; r++) begin
         logic [2:0] f3; logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (r % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         run_op($sformatf("rand%0d_f3_%0d", r, f3), f3, a, b, model(f3, a, b));
      end

      // Operands are latched: a different M op held valid through BUSY is ignored.
      @(posedge clk); #1;
      issue("hold_divu", 3'd5, 32'd1000, 32'd9, 32'd111, 1'b1);
      ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd5; InValid = 1'b1;
      wait_done("hold_divu");
      idle_inputs();

      // Flush at cycle 10 of a DIV, then a MUL issued at cycle 12.
      @(posedge clk); #1;
      issue("flush_div", 3'd4, 32'd100, 32'd7, 32'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      Flush = 1'b1;
      #1;
      check("flush_busy_stall", 64'(md_stall), 64'd1);
      @(posedge clk); #1;
      Flush = 1'b0;
      @(negedge clk);
      check("flush_idle_stall", 64'(md_stall), 64'd0);
      check("flush_no_valid", 64'(md_valid), 64'd0);
      @(posedge clk); #1;
      issue("after_flush_mul", 3'd0, 32'd6, 32'd7, 32'd42, 1'b1);
      wait_done("after_flush_mul");

      // Asynchronous reset at cycle 20 of a MUL.
      @(posedge clk); #1;
      issue("rst_mul", 3'd0, 32'd1234, 32'd5678, 32'd0, 1'b0);
      repeat (19) @(posedge clk);
      #1;
      check("pre_reset_stall", 64'(md_stall), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_stall", 64'(md_stall), 64'd0);
      check("async_reset_valid", 64'(md_valid), 64'd0);
      check("async_reset_result", 64'(md_result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_reset_divu", 3'd5, 32'd9, 32'd3, 32'd3);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
